// File: rtl/alu_exec_unit.sv
// Handshaked ADD/SUB/MUL execution unit. ADD and SUB finish in one cycle.
// MUL runs an iterative radix-2 shift-add over WIDTH cycles with fixed latency.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_flag,
  output logic             out_err,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DONE     = 2'd2
  } state_t;

  state_t state, state_next;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               last_iter;
  logic               accept;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  assign sum       = {1'b0, in_a} + {1'b0, in_b};
  assign diff      = {1'b0, in_a} - {1'b0, in_b};
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // mcand holds a already shifted left by cnt; mplier presents the current bit of b at bit 0
  assign acc_next  = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (in_valid) state_next = (in_op == OP_MUL) ? MUL_BUSY : DONE;
      MUL_BUSY: if (last_iter) state_next = DONE;
      DONE:     if (out_ready) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      out_result <= '0;
      out_flag   <= 1'b0;
      out_err    <= 1'b0;
      out_tag    <= '0;
    end else if (accept) begin
      out_tag <= in_tag;
      case (in_op)
        OP_ADD: begin
          out_result <= sum[WIDTH-1:0];
          out_flag   <= sum[WIDTH];
          out_err    <= 1'b0;
        end
        OP_SUB: begin
          out_result <= diff[WIDTH-1:0];
          out_flag   <= diff[WIDTH];
          out_err    <= 1'b0;
        end
        OP_MUL: begin
          acc    <= '0;
          cnt    <= '0;
          mcand  <= {{WIDTH{1'b0}}, in_a};
          mplier <= in_b;
        end
        default: begin
          out_result <= '0;
          out_flag   <= 1'b0;
          out_err    <= 1'b1;
        end
      endcase
    end else if (state == MUL_BUSY) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last_iter) begin
        out_result <= acc_next[WIDTH-1:0];
        out_flag   <= |acc_next[2*WIDTH-1:WIDTH];
        out_err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench: an 8-bit instance for ADD/MUL/backpressure/reset
// scenarios and a 32-bit instance for SUB wraparound.
module tb_alu_exec_unit;

  logic clk;
  logic rst;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] in_a8, in_b8, out_result8;
  logic [1:0] in_op8;
  logic [3:0] in_tag8, out_tag8;
  logic       out_flag8, out_err8, busy8;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] in_a32, in_b32, out_result32;
  logic [1:0]  in_op32;
  logic [3:0]  in_tag32, out_tag32;
  logic        out_flag32, out_err32, busy32;

  int checks;
  int errors;

  alu_exec_unit #(.WIDTH(8), .TAG_W(4)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_a(in_a8), .in_b(in_b8), .in_op(in_op8), .in_tag(in_tag8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_result(out_result8), .out_flag(out_flag8), .out_err(out_err8),
    .out_tag(out_tag8), .busy(busy8)
  );

  alu_exec_unit #(.WIDTH(32), .TAG_W(4)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .in_a(in_a32), .in_b(in_b32), .in_op(in_op32), .in_tag(in_tag32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .out_result(out_result32), .out_flag(out_flag32), .out_err(out_err32),
    .out_tag(out_tag32), .busy(busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one instruction on the 8-bit unit; returns at the negedge after the accept edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [3:0] tag);
    @(negedge clk);
    in_valid8 = 1'b1; in_a8 = a; in_b8 = b; in_op8 = op; in_tag8 = tag;
    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++; $display("[TB] FAIL issue8_ready: got %b want 1", in_ready8);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] op, input logic [3:0] tag);
    @(negedge clk);
    in_valid32 = 1'b1; in_a32 = a; in_b32 = b; in_op32 = op; in_tag32 = tag;
    checks++;
    if (in_ready32 !== 1'b1) begin
      errors++; $display("[TB] FAIL issue32_ready: got %b want 1", in_ready32);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid32 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid8, busy8, in_ready8, out_flag8, out_err8} !== 5'b0) begin
      errors++; $display("[TB] FAIL reset_ctrl: got %b want 00000",
                         {out_valid8, busy8, in_ready8, out_flag8, out_err8});
    end
    checks++;
    if (out_result8 !== 8'h00 || out_tag8 !== 4'h0) begin
      errors++; $display("[TB] FAIL reset_data: got %h/%h want 00/0", out_result8, out_tag8);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1 || in_ready32 !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b%b want 11", in_ready8, in_ready32);
    end
  endtask

  task automatic test_add;
    out_ready8 = 1'b1;
    issue8(8'hF0, 8'h20, 2'd0, 4'h5);
    checks++;
    if ({out_valid8, out_result8, out_flag8, out_err8, out_tag8} !== {1'b1, 8'h10, 1'b1, 1'b0, 4'h5}) begin
      errors++; $display("[TB] FAIL add_result: got v=%b r=%h f=%b e=%b t=%h want v=1 r=10 f=1 e=0 t=5",
                         out_valid8, out_result8, out_flag8, out_err8, out_tag8);
    end
    checks++;
    if (in_ready8 !== 1'b0) begin
      errors++; $display("[TB] FAIL add_ready_low: got %b want 0", in_ready8);
    end
    @(negedge clk);
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
      errors++; $display("[TB] FAIL add_release: got rdy=%b v=%b want 1 0", in_ready8, out_valid8);
    end
  endtask

  task automatic test_sub;
    out_ready32 = 1'b1;
    issue32(32'd5, 32'd7, 2'd1, 4'h3);
    checks++;
    if ({out_valid32, out_result32, out_flag32, out_err32} !== {1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0}) begin
      errors++; $display("[TB] FAIL sub_wrap: got v=%b r=%h f=%b e=%b want 1 fffffffe 1 0",
                         out_valid32, out_result32, out_flag32, out_err32);
    end
    issue32(32'd7, 32'd5, 2'd1, 4'h4);
    checks++;
    if ({out_valid32, out_result32, out_flag32, out_tag32} !== {1'b1, 32'd2, 1'b0, 4'h4}) begin
      errors++; $display("[TB] FAIL sub_pos: got v=%b r=%h f=%b t=%h want 1 00000002 0 4",
                         out_valid32, out_result32, out_flag32, out_tag32);
    end
  endtask

  task automatic run_mul8(input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag,
                          input logic [7:0] exp_r, input logic exp_f);
    out_ready8 = 1'b1;
    issue8(a, b, 2'd2, tag);
    for (int k = 1; k <= 9; k++) begin
      checks++;
      if (in_ready8 !== 1'b0 || out_valid8 !== (k == 9)) begin
        errors++; $display("[TB] FAIL mul_timing k=%0d: got rdy=%b v=%b want 0 %b",
                           k, in_ready8, out_valid8, (k == 9));
      end
      if (k < 9) @(negedge clk);
    end
    checks++;
    if ({out_result8, out_flag8, out_err8, out_tag8} !== {exp_r, exp_f, 1'b0, tag}) begin
      errors++; $display("[TB] FAIL mul_result: got r=%h f=%b e=%b t=%h want r=%h f=%b e=0 t=%h",
                         out_result8, out_flag8, out_err8, out_tag8, exp_r, exp_f, tag);
    end
    @(negedge clk);
  endtask

  task automatic test_mul;
    run_mul8(8'h0F, 8'h11, 4'h9, 8'hFF, 1'b0);
    run_mul8(8'hFF, 8'hFF, 4'hA, 8'h01, 1'b1);
  endtask

  task automatic test_backpressure;
    out_ready8 = 1'b0;
    issue8(8'd3, 8'd4, 2'd0, 4'h2);
    for (int k = 0; k < 5; k++) begin
      in_valid8 = 1'b1; in_a8 = 8'd1; in_b8 = 8'd1; in_op8 = 2'd0; in_tag8 = 4'h7;
      checks++;
      if ({out_valid8, in_ready8, out_result8, out_tag8, out_flag8} !== {1'b1, 1'b0, 8'd7, 4'h2, 1'b0}) begin
        errors++; $display("[TB] FAIL bp_hold k=%0d: got v=%b rdy=%b r=%h t=%h f=%b want 1 0 07 2 0",
                           k, out_valid8, in_ready8, out_result8, out_tag8, out_flag8);
      end
      @(negedge clk);
    end
    out_ready8 = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_release: got v=%b rdy=%b want 0 1", out_valid8, in_ready8);
    end
    @(negedge clk);
    in_valid8 = 1'b0;
    checks++;
    if ({out_valid8, out_result8, out_tag8} !== {1'b1, 8'd2, 4'h7}) begin
      errors++; $display("[TB] FAIL bp_next: got v=%b r=%h t=%h want 1 02 7",
                         out_valid8, out_result8, out_tag8);
    end
    @(negedge clk);
  endtask

  task automatic test_illegal;
    out_ready8 = 1'b1;
    issue8(8'hAA, 8'hAA, 2'd3, 4'h1);
    checks++;
    if ({out_valid8, out_result8, out_err8, out_flag8, out_tag8} !== {1'b1, 8'h00, 1'b1, 1'b0, 4'h1}) begin
      errors++; $display("[TB] FAIL illegal: got v=%b r=%h e=%b f=%b t=%h want 1 00 1 0 1",
                         out_valid8, out_result8, out_err8, out_flag8, out_tag8);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul;
    out_ready8 = 1'b1;
    issue8(8'h0F, 8'h11, 2'd2, 4'h4);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid8, busy8, in_ready8, out_result8, out_flag8, out_err8, out_tag8} !== 17'b0) begin
      errors++; $display("[TB] FAIL midrst_clear: got v=%b b=%b rdy=%b r=%h f=%b e=%b t=%h want all 0",
                         out_valid8, busy8, in_ready8, out_result8, out_flag8, out_err8, out_tag8);
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
        errors++; $display("[TB] FAIL midrst_stale k=%0d: got v=%b rdy=%b want 0 1", k, out_valid8, in_ready8);
      end
    end
    issue8(8'd1, 8'd1, 2'd0, 4'hB);
    checks++;
    if ({out_valid8, out_result8, out_flag8, out_tag8} !== {1'b1, 8'd2, 1'b0, 4'hB}) begin
      errors++; $display("[TB] FAIL midrst_add: got v=%b r=%h f=%b t=%h want 1 02 0 b",
                         out_valid8, out_result8, out_flag8, out_tag8);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    in_valid8 = 1'b0; in_a8 = '0; in_b8 = '0; in_op8 = '0; in_tag8 = '0; out_ready8 = 1'b0;
    in_valid32 = 1'b0; in_a32 = '0; in_b32 = '0; in_op32 = '0; in_tag32 = '0; out_ready32 = 1'b0;
    test_reset;
    test_add;
    test_sub;
    test_mul;
    test_backpressure;
    test_illegal;
    test_reset_mid_mul;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised, handshaked execution unit for the team's {ADD, SUB, MUL} instruction set.
- Accepts one instruction (operands a, b, opcode, tag) per transaction and returns a registered result with a status flag.
- ADD and SUB complete in a single cycle. MUL uses an iterative radix-2 shift-add multiplier, replacing the combinational multiply helper.
- Sits between the instruction issue stage and writeback. Supports backpressure on both sides.

Parameters:
- WIDTH, 32, operand and result width in bits (>=2).
- TAG_W, 4, width of the opaque instruction tag passed through to the result.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  unit can accept an instruction.
- in_a  input  WIDTH  operand a (unsigned).
- in_b  input  WIDTH  operand b (unsigned).
- in_op  input  2  opcode: 0=ADD, 1=SUB, 2=MUL, 3=illegal.
- in_tag  input  TAG_W  tag, returned unchanged.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  result.
- out_flag  output  1  ADD: carry-out; SUB: borrow (a<b); MUL: high half of full product nonzero.
- out_err  output  1  illegal opcode.
- out_tag  output  TAG_W  tag of this result.
- busy  output  1  state != IDLE.

Behaviour:
- States: IDLE, MUL_BUSY, DONE.
- Reset (rst=1 at a clock edge, any state):
  - state=IDLE.
  - out_valid=0, out_result=0, out_flag=0, out_err=0, out_tag=0, busy=0.
  - Multiplier accumulator and counter cleared.
  - An in-flight MUL is discarded and never reported.
- in_ready = (state==IDLE) && !rst. It is combinational from state only, never from in_valid.
- Accept occurs at edge T when in_valid && in_ready. Inputs are captured at T and may change afterwards.
- ADD (op 0) accepted at T:
  - out_result = (a+b) mod 2^WIDTH; out_flag = carry-out; err=0.
  - DONE and out_valid=1 from T+1.
- SUB (op 1) accepted at T:
  - out_result = (a-b) mod 2^WIDTH; out_flag = (a<b); err=0.
  - DONE at T+1.
- Illegal op (3) accepted at T:
  - out_result=0, out_flag=0, out_err=1.
  - DONE at T+1.
- MUL (op 2) accepted at T:
  - Enter MUL_BUSY with a 2*WIDTH-bit accumulator = 0 and counter = 0.
  - Each cycle, examine one bit of b, LSB first. If the bit is 1, add a shifted left by the counter.
  - After exactly WIDTH iterations, go to DONE. out_valid=1 first at T+WIDTH+1.
  - out_result = low WIDTH bits of a*b; out_flag = (high WIDTH bits != 0).
  - No early termination: latency is fixed regardless of the operand values.
- DONE:
  - All out_* fields are held stable while out_valid=1 && out_ready=0.
  - When out_valid && out_ready at edge E: IDLE at E (out_valid=0 after E), in_ready=1 in cycle E+1.
  - A new accept is therefore possible no earlier than E+1.
  - Sustained ADD/SUB throughput is 1 instruction per 2 cycles.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- out_tag = in_tag captured at accept.
- Illegal opcode never asserts out_flag.

Test Plan:
- Reset, then ADD at WIDTH=8, a=0xF0, b=0x20, out_ready=1 -> out_valid at T+1, out_result=0x10, flag=1, err=0, tag echoed; in_ready back to 1 one cycle later.
- SUB at WIDTH=32, a=5, b=7 -> out_result=0xFFFFFFFE, flag=1; then a=7, b=5 -> result 2, flag=0.
- MUL at WIDTH=8:
  - a=0x0F, b=0x11 -> out_valid exactly at T+9, result=0xFF, flag=0, in_ready=0 for cycles T+1..T+9.
  - a=0xFF, b=0xFF -> result=0x01, flag=1.
- Backpressure: ADD with out_ready=0 for 5 cycles -> out_* stable, in_ready=0 and a concurrent in_valid not accepted. Raise out_ready -> single handshake, next instruction accepted the following cycle.
- Illegal op=3, a=b=0xAA -> out_result=0, err=1, flag=0, latency 1.
- Reset mid-MUL: assert rst at T+3 of an 8-cycle MUL -> all outputs 0, IDLE, in_ready=1 after deassertion, no stale result. Next ADD 1+1 -> result 2.
